// File: rtl/orca_pkg.sv
// Shared types and flit-field constants for the manycore
// traffic generator and its receive sink.
package orca_pkg;

  localparam int ADDR_W = 16;
  localparam int SEQ_W  = 8;
  localparam int IDX_W  = 8;
  localparam int PLD_W  = SEQ_W + IDX_W;

  typedef enum logic [1:0] {
    T_IDLE,
    T_HEADER,
    T_SIZE,
    T_PAYLOAD
  } tx_state_t;

  typedef enum logic [1:0] {
    R_HEADER,
    R_SIZE,
    R_PAYLOAD
  } rx_state_t;

  function automatic logic [PLD_W-1:0] payload_flit(
    input logic [SEQ_W-1:0] seq,
    input logic [IDX_W-1:0] idx
  );
    return {seq, idx};
  endfunction

endpackage

// File: rtl/manycore_traffic_rx.sv
// Receive sink: walks header/size/payload framing and
// counts completed packets.
module manycore_traffic_rx
  import orca_pkg::*;
#(
  parameter int FLIT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic [31:0]           recv_count
);

  localparam logic [FLIT_WIDTH-1:0] ONE =
    FLIT_WIDTH'(1);

  rx_state_t             state;
  logic [FLIT_WIDTH-1:0] remaining;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= R_HEADER;
      remaining  <= '0;
      recv_count <= '0;
    end else if (rx) begin
      unique case (state)
        R_HEADER: state <= R_SIZE;
        R_SIZE: begin
          if (data_i == '0) begin
            state      <= R_HEADER;
            recv_count <= recv_count + 32'd1;
          end else begin
            remaining <= data_i;
            state     <= R_PAYLOAD;
          end
        end
        R_PAYLOAD: begin
          if (remaining == ONE) begin
            state      <= R_HEADER;
            recv_count <= recv_count + 32'd1;
          end else begin
            remaining <= remaining - ONE;
          end
        end
        default: state <= R_HEADER;
      endcase
    end
  end

endmodule

// File: rtl/manycore_traffic_gen.sv
// Periodic NoC packet generator with credit flow control
// and an unconditional receive sink.
module manycore_traffic_gen
  import orca_pkg::*;
#(
  parameter int          FLIT_WIDTH    = 16,
  parameter logic [15:0] SRC_ADDRESS   = 16'h0000,
  parameter logic [15:0] DEST_ADDRESS  = 16'h0000,
  parameter int          PAYLOAD_FLITS = 8,
  parameter int          PERIOD        = 250_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  output logic [31:0]           sent_count,
  output logic [31:0]           recv_count,
  output logic [31:0]           missed_count,
  output logic                  busy
);

  if (FLIT_WIDTH < 16 || PAYLOAD_FLITS < 0 ||
      PAYLOAD_FLITS > 255 || PERIOD < 2 ||
      SRC_ADDRESS[15:12] != 4'h0 ||
      SRC_ADDRESS[7:4] != 4'h0) begin : g_bad_param
    $error("manycore_traffic_gen: illegal parameter");
  end

  localparam logic [IDX_W-1:0] SIZE =
    IDX_W'(PAYLOAD_FLITS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(PAYLOAD_FLITS - 1);
  localparam logic [31:0] WRAP = 32'(PERIOD - 1);

  tx_state_t        state;
  logic [31:0]      period_cnt;
  logic             pending;
  logic [SEQ_W-1:0] seq;
  logic [IDX_W-1:0] idx;
  logic             release_hit;
  logic             consume;
  logic             last_xfer;

  assign release_hit = enable && (period_cnt == WRAP);
  assign consume     = (state == T_IDLE) && pending;
  assign busy        = (state != T_IDLE);

  // Final flit is either the size flit of an empty
  // packet or the last payload flit.
  assign last_xfer = credit_i &&
    ((state == T_SIZE && PAYLOAD_FLITS == 0) ||
     (state == T_PAYLOAD && idx == LAST));

  always_ff @(posedge clock) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (period_cnt == WRAP) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 32'd1;
    end
  end

  // A release that finds one already queued is dropped
  // and counted; the queued one still stands.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending      <= 1'b0;
      missed_count <= '0;
    end else if (release_hit) begin
      pending <= 1'b1;
      if (pending) begin
        missed_count <= missed_count + 32'd1;
      end
    end else if (consume) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      credit_o <= 1'b0;
    end else begin
      credit_o <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= T_IDLE;
      tx         <= 1'b0;
      data_o     <= '0;
      idx        <= '0;
      seq        <= '0;
      sent_count <= '0;
    end else if (last_xfer) begin
      state      <= T_IDLE;
      tx         <= 1'b0;
      data_o     <= '0;
      seq        <= seq + SEQ_W'(1);
      sent_count <= sent_count + 32'd1;
    end else begin
      unique case (state)
        T_IDLE: begin
          if (pending) begin
            state  <= T_HEADER;
            tx     <= 1'b1;
            data_o <= FLIT_WIDTH'(DEST_ADDRESS);
          end
        end
        T_HEADER: begin
          if (credit_i) begin
            state  <= T_SIZE;
            data_o <= FLIT_WIDTH'(SIZE);
          end
        end
        T_SIZE: begin
          if (credit_i) begin
            state  <= T_PAYLOAD;
            idx    <= '0;
            data_o <= FLIT_WIDTH'(
              payload_flit(seq, '0));
          end
        end
        T_PAYLOAD: begin
          if (credit_i) begin
            idx    <= idx + IDX_W'(1);
            data_o <= FLIT_WIDTH'(
              payload_flit(seq, idx + IDX_W'(1)));
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

  manycore_traffic_rx #(
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data_i     (data_i),
    .recv_count (recv_count)
  );

endmodule
